// File: rtl/id_stage_pipe.sv
// Instruction decode stage: decodes one instruction per cycle, resolves branches and jumps,
// detects load-use hazards and drives the registered ID/EX pipeline entry.
module id_stage_pipe #(
  parameter int WORD_LEN     = 16,
  parameter int REG_ADDR_LEN = 4,
  parameter int IMM_LEN      = 8,
  parameter int R0_ZERO      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid,
  input  logic [WORD_LEN-1:0]     instruction,
  input  logic [WORD_LEN-1:0]     reg1,
  input  logic [WORD_LEN-1:0]     reg2,
  input  logic                    ex_stall,
  input  logic                    flush,
  output logic [REG_ADDR_LEN-1:0] src1,
  output logic [REG_ADDR_LEN-1:0] src2,
  output logic                    hazard_stall,
  output logic                    br_taken,
  output logic [WORD_LEN-1:0]     br_offset,
  output logic                    ex_valid,
  output logic [3:0]              ex_cmd,
  output logic [WORD_LEN-1:0]     ex_val1,
  output logic [WORD_LEN-1:0]     ex_val2,
  output logic [WORD_LEN-1:0]     ex_st_val,
  output logic [REG_ADDR_LEN-1:0] ex_dest,
  output logic [REG_ADDR_LEN-1:0] ex_src1,
  output logic [REG_ADDR_LEN-1:0] ex_src2_forw,
  output logic                    ex_mem_r_en,
  output logic                    ex_mem_w_en,
  output logic                    ex_wb_en
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b0101;
  localparam logic [3:0] OP_LD   = 4'b0110;
  localparam logic [3:0] OP_ST   = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1010;

  localparam logic R0_EN = (R0_ZERO != 0);

  typedef struct packed {
    logic                    valid;
    logic [3:0]              cmd;
    logic [WORD_LEN-1:0]     val1;
    logic [WORD_LEN-1:0]     val2;
    logic [WORD_LEN-1:0]     st_val;
    logic [REG_ADDR_LEN-1:0] dest;
    logic [REG_ADDR_LEN-1:0] src1;
    logic [REG_ADDR_LEN-1:0] src2_forw;
    logic                    mem_r_en;
    logic                    mem_w_en;
    logic                    wb_en;
  } id_ex_t;

  logic [3:0]              opcode;
  logic [REG_ADDR_LEN-1:0] fld_a;
  logic [REG_ADDR_LEN-1:0] fld_b;
  logic [WORD_LEN-1:0]     imm_ext;

  logic [3:0] dec_cmd;
  logic       dec_wb_en;
  logic       dec_mem_r_en;
  logic       dec_mem_w_en;
  logic       dec_is_imm;
  logic       dec_use1;
  logic       dec_use2;
  logic       dec_src2_a;
  logic       dec_beq;
  logic       dec_bne;
  logic       dec_jmp;

  logic   dest_is_zero;
  logic   src_match;
  logic   br_cond;
  id_ex_t ex_q;
  id_ex_t ex_next;

  assign opcode  = instruction[WORD_LEN-1 -: 4];
  assign fld_a   = instruction[8 +: REG_ADDR_LEN];
  assign fld_b   = instruction[4 +: REG_ADDR_LEN];
  assign imm_ext = {{(WORD_LEN-IMM_LEN){instruction[IMM_LEN-1]}}, instruction[IMM_LEN-1:0]};

  always_comb begin
    dec_cmd      = OP_ADD;
    dec_wb_en    = 1'b0;
    dec_mem_r_en = 1'b0;
    dec_mem_w_en = 1'b0;
    dec_is_imm   = 1'b0;
    dec_use1     = 1'b0;
    dec_use2     = 1'b0;
    dec_src2_a   = 1'b0;
    dec_beq      = 1'b0;
    dec_bne      = 1'b0;
    dec_jmp      = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        dec_cmd   = opcode;
        dec_wb_en = 1'b1;
        dec_use1  = 1'b1;
        dec_use2  = 1'b1;
      end
      OP_SLL: begin
        dec_cmd    = opcode;
        dec_wb_en  = 1'b1;
        dec_is_imm = 1'b1;
        dec_use1   = 1'b1;
      end
      OP_ADDI: begin
        dec_wb_en  = 1'b1;
        dec_is_imm = 1'b1;
        dec_use1   = 1'b1;
      end
      OP_LD: begin
        dec_wb_en    = 1'b1;
        dec_mem_r_en = 1'b1;
        dec_is_imm   = 1'b1;
        dec_use1     = 1'b1;
      end
      OP_ST: begin
        dec_mem_w_en = 1'b1;
        dec_is_imm   = 1'b1;
        dec_use1     = 1'b1;
        dec_use2     = 1'b1;
        dec_src2_a   = 1'b1;
      end
      OP_BEQ: begin
        dec_use1   = 1'b1;
        dec_use2   = 1'b1;
        dec_src2_a = 1'b1;
        dec_beq    = 1'b1;
      end
      OP_BNE: begin
        dec_use1   = 1'b1;
        dec_use2   = 1'b1;
        dec_src2_a = 1'b1;
        dec_bne    = 1'b1;
      end
      OP_JMP: dec_jmp = 1'b1;
      default: ;
    endcase
  end

  assign src1      = fld_a;
  assign src2      = dec_src2_a ? fld_a : fld_b;
  assign br_offset = imm_ext;

  // A load in EX whose destination feeds an operand we read forces one bubble.
  assign dest_is_zero = R0_EN && (ex_q.dest == '0);
  assign src_match    = (dec_use1 && (src1 == ex_q.dest)) || (dec_use2 && (src2 == ex_q.dest));
  assign hazard_stall = instr_valid && ex_q.valid && ex_q.mem_r_en && !dest_is_zero && src_match;

  assign br_cond  = (dec_beq && (reg1 == reg2)) || (dec_bne && (reg1 != reg2)) || dec_jmp;
  assign br_taken = instr_valid && !hazard_stall && !ex_stall && br_cond;

  always_comb begin
    ex_next           = '0;
    ex_next.valid     = instr_valid;
    ex_next.cmd       = dec_cmd;
    ex_next.val1      = reg1;
    ex_next.val2      = dec_is_imm ? imm_ext : reg2;
    ex_next.st_val    = reg2;
    ex_next.dest      = fld_a;
    ex_next.src1      = src1;
    ex_next.src2_forw = dec_is_imm ? '0 : src2;
    ex_next.mem_r_en  = dec_mem_r_en;
    ex_next.mem_w_en  = dec_mem_w_en;
    ex_next.wb_en     = dec_wb_en;
  end

  // Priority: reset, flush, downstream stall (hold), hazard bubble, normal load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q <= '0;
    end else if (flush) begin
      ex_q <= '0;
    end else if (ex_stall) begin
      ex_q <= ex_q;
    end else if (hazard_stall) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_next;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_cmd       = ex_q.cmd;
  assign ex_val1      = ex_q.val1;
  assign ex_val2      = ex_q.val2;
  assign ex_st_val    = ex_q.st_val;
  assign ex_dest      = ex_q.dest;
  assign ex_src1      = ex_q.src1;
  assign ex_src2_forw = ex_q.src2_forw;
  assign ex_mem_r_en  = ex_q.mem_r_en;
  assign ex_mem_w_en  = ex_q.mem_w_en;
  assign ex_wb_en     = ex_q.wb_en;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: each vector carries hand-computed combinational results
// and the ID/EX entry expected after the next clock edge, checked by a separate monitor.
module tb_id_stage_pipe;

  localparam int EW = 70;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instruction;
  logic [15:0] reg1;
  logic [15:0] reg2;
  logic        ex_stall;
  logic        flush;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        hazard_stall;
  logic        br_taken;
  logic [15:0] br_offset;
  logic        ex_valid;
  logic [3:0]  ex_cmd;
  logic [15:0] ex_val1;
  logic [15:0] ex_val2;
  logic [15:0] ex_st_val;
  logic [3:0]  ex_dest;
  logic [3:0]  ex_src1;
  logic [3:0]  ex_src2_forw;
  logic        ex_mem_r_en;
  logic        ex_mem_w_en;
  logic        ex_wb_en;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  id_stage_pipe dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
    .reg1(reg1), .reg2(reg2), .ex_stall(ex_stall), .flush(flush),
    .src1(src1), .src2(src2), .hazard_stall(hazard_stall), .br_taken(br_taken),
    .br_offset(br_offset), .ex_valid(ex_valid), .ex_cmd(ex_cmd), .ex_val1(ex_val1),
    .ex_val2(ex_val2), .ex_st_val(ex_st_val), .ex_dest(ex_dest), .ex_src1(ex_src1),
    .ex_src2_forw(ex_src2_forw), .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en),
    .ex_wb_en(ex_wb_en)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Entry kinds: 0 = every field, 1 = valid/cmd/enables, 2 = valid/enables.
  function automatic logic [EW-1:0] fe(input logic v, input logic [3:0] cmd,
      input logic [15:0] v1, input logic [15:0] v2, input logic [15:0] st,
      input logic [3:0] dest, input logic [3:0] s1, input logic [3:0] s2f,
      input logic mr, input logic mw, input logic wb);
    return {2'd0, v, cmd, v1, v2, st, dest, s1, s2f, mr, mw, wb};
  endfunction

  function automatic logic [EW-1:0] ce(input logic v, input logic [3:0] cmd,
      input logic mr, input logic mw, input logic wb);
    return {2'd1, v, cmd, 48'd0, 12'd0, mr, mw, wb};
  endfunction

  function automatic logic [EW-1:0] ve(input logic v);
    return {2'd2, v, 4'd0, 48'd0, 12'd0, 3'b000};
  endfunction

  function automatic logic [EW-1:0] ze();
    return fe(1'b0, 4'd0, 16'd0, 16'd0, 16'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [EW-1:0] masked(input logic [EW-1:0] e, input logic [1:0] kind);
    logic [EW-1:0] m;
    m = e;
    m[EW-1:EW-2] = 2'd0;
    if (kind != 2'd0) m[62:3] = '0;
    if (kind == 2'd2) m[66:63] = '0;
    return m;
  endfunction

  // monitor: compares the registered entry after each active edge
  always @(posedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] act;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {2'd0, ex_valid, ex_cmd, ex_val1, ex_val2, ex_st_val, ex_dest, ex_src1,
             ex_src2_forw, ex_mem_r_en, ex_mem_w_en, ex_wb_en};
      check("id_ex_entry", masked(act, e[EW-1:EW-2]), masked(e, e[EW-1:EW-2]));
    end
  end

  // driver: chk bits select hazard, br_taken, br_offset, src1/src2 checks
  task automatic step(input logic r, input logic iv, input logic [15:0] ins,
      input logic [15:0] r1, input logic [15:0] r2, input logic stl, input logic fl,
      input logic [3:0] chk, input logic hz, input logic br, input logic [15:0] off,
      input logic [3:0] s1, input logic [3:0] s2, input logic [EW-1:0] exp);
    #1;
    rst = r; instr_valid = iv; instruction = ins; reg1 = r1; reg2 = r2;
    ex_stall = stl; flush = fl;
    #4;
    if (chk[0]) check("hazard_stall", EW'(hazard_stall), EW'(hz));
    if (chk[1]) check("br_taken", EW'(br_taken), EW'(br));
    if (chk[2]) check("br_offset", EW'(br_offset), EW'(off));
    if (chk[3]) begin
      check("src1", EW'(src1), EW'(s1));
      check("src2", EW'(src2), EW'(s2));
    end
    exp_q.push_back(exp);
    @(posedge clk);
  endtask

  localparam logic [3:0] CK_HB = 4'b0011;
  localparam logic [3:0] CK_ALL = 4'b1111;

  initial begin
    rst = 1'b0; instr_valid = 1'b0; instruction = '0; reg1 = '0; reg2 = '0;
    ex_stall = 1'b0; flush = 1'b0;
    @(posedge clk);

    repeat (2) step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                    16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    4'b0001, 1'b0, 1'b0, 16'd0, 4'd0, 4'd0, ze());

    // ALU, immediate, load and load-use
    step(1, 1, 16'h0312, 16'd5, 16'd7, 0, 0, CK_ALL, 0, 0, 16'h0012, 4'd3, 4'd1,
         fe(1, 4'h0, 16'd5, 16'd7, 16'd7, 4'd3, 4'd3, 4'd1, 0, 0, 1));
    step(1, 1, 16'h52F0, 16'h0011, 16'h0022, 0, 0, CK_ALL, 0, 0, 16'hFFF0, 4'd2, 4'hF,
         fe(1, 4'h0, 16'h0011, 16'hFFF0, 16'h0022, 4'd2, 4'd2, 4'd0, 0, 0, 1));
    step(1, 1, 16'h1678, 16'd100, 16'd30, 0, 0, CK_ALL, 0, 0, 16'h0078, 4'd6, 4'd7,
         fe(1, 4'h1, 16'd100, 16'd30, 16'd30, 4'd6, 4'd6, 4'd7, 0, 0, 1));
    step(1, 1, 16'h6403, 16'h1000, 16'h0055, 0, 0, CK_ALL, 0, 0, 16'h0003, 4'd4, 4'd0,
         fe(1, 4'h0, 16'h1000, 16'h0003, 16'h0055, 4'd4, 4'd4, 4'd0, 1, 0, 1));
    step(1, 1, 16'h0541, 16'd9, 16'd2, 0, 0, CK_ALL, 1, 0, 16'h0041, 4'd5, 4'd4, ve(0));
    step(1, 1, 16'h0541, 16'd9, 16'd2, 0, 0, CK_HB, 0, 0, 16'h0, 4'd0, 4'd0,
         fe(1, 4'h0, 16'd9, 16'd2, 16'd2, 4'd5, 4'd5, 4'd4, 0, 0, 1));
    step(1, 1, 16'h6001, 16'd0, 16'd0, 0, 0, CK_ALL, 0, 0, 16'h0001, 4'd0, 4'd0,
         fe(1, 4'h0, 16'd0, 16'd1, 16'd0, 4'd0, 4'd0, 4'd0, 1, 0, 1));
    step(1, 1, 16'h0501, 16'd3, 16'd4, 0, 0, CK_ALL, 0, 0, 16'h0001, 4'd5, 4'd0,
         fe(1, 4'h0, 16'd3, 16'd4, 16'd4, 4'd5, 4'd5, 4'd0, 0, 0, 1));

    // branches and jump
    step(1, 1, 16'h8183, 16'd9, 16'd9, 0, 0, CK_ALL, 0, 1, 16'hFF83, 4'd1, 4'd1, ve(1));
    step(1, 1, 16'h8183, 16'd9, 16'd8, 0, 0, CK_HB, 0, 0, 16'h0, 4'd0, 4'd0, ve(1));
    step(1, 1, 16'h9105, 16'd9, 16'd9, 0, 0, CK_ALL, 0, 0, 16'h0005, 4'd1, 4'd1, ve(1));
    step(1, 1, 16'h9105, 16'd9, 16'd8, 0, 0, CK_HB, 0, 1, 16'h0, 4'd0, 4'd0, ve(1));
    step(1, 1, 16'hA0FE, 16'd1, 16'd2, 0, 0, CK_ALL, 0, 1, 16'hFFFE, 4'd0, 4'hF, ve(1));
    step(1, 1, 16'h8183, 16'd9, 16'd9, 1, 0, CK_HB, 0, 0, 16'h0, 4'd0, 4'd0, ve(1));

    // downstream stall holds the entry for three cycles
    step(1, 1, 16'h3234, 16'h0F0F, 16'h00FF, 0, 0, CK_ALL, 0, 0, 16'h0034, 4'd2, 4'd3,
         fe(1, 4'h3, 16'h0F0F, 16'h00FF, 16'h00FF, 4'd2, 4'd2, 4'd3, 0, 0, 1));
    repeat (3)
      step(1, 1, 16'h2567, 16'd1, 16'd2, 1, 0, CK_ALL, 0, 0, 16'h0067, 4'd5, 4'd6,
           fe(1, 4'h3, 16'h0F0F, 16'h00FF, 16'h00FF, 4'd2, 4'd2, 4'd3, 0, 0, 1));
    step(1, 1, 16'h7910, 16'h0200, 16'hBEEF, 0, 0, CK_ALL, 0, 0, 16'h0010, 4'd9, 4'd9,
         fe(1, 4'h0, 16'h0200, 16'h0010, 16'hBEEF, 4'd9, 4'd9, 4'd0, 0, 1, 0));

    // flush, and flush together with a hazard
    step(1, 1, 16'h0312, 16'd5, 16'd7, 0, 1, CK_ALL, 0, 0, 16'h0012, 4'd3, 4'd1, ze());
    step(1, 1, 16'h6403, 16'h1000, 16'h0055, 0, 0, CK_ALL, 0, 0, 16'h0003, 4'd4, 4'd0,
         fe(1, 4'h0, 16'h1000, 16'h0003, 16'h0055, 4'd4, 4'd4, 4'd0, 1, 0, 1));
    step(1, 1, 16'h0541, 16'd9, 16'd2, 0, 1, CK_ALL, 1, 0, 16'h0041, 4'd5, 4'd4, ze());
    step(1, 1, 16'h0541, 16'd9, 16'd2, 0, 0, CK_HB, 0, 0, 16'h0, 4'd0, 4'd0,
         fe(1, 4'h0, 16'd9, 16'd2, 16'd2, 4'd5, 4'd5, 4'd4, 0, 0, 1));

    // undefined opcode and invalid NOP
    step(1, 1, 16'hC123, 16'd1, 16'd2, 0, 0, CK_ALL, 0, 0, 16'h0023, 4'd1, 4'd2,
         ce(1, 4'h0, 0, 0, 0));
    step(1, 0, 16'hF000, 16'd0, 16'd0, 0, 0, CK_ALL, 0, 0, 16'h0000, 4'd0, 4'd0,
         ce(0, 4'h0, 0, 0, 0));

    // load-use through src1, then reset while the hazard is raised
    step(1, 1, 16'h6403, 16'h1000, 16'h0055, 0, 0, CK_HB, 0, 0, 16'h0, 4'd0, 4'd0,
         fe(1, 4'h0, 16'h1000, 16'h0003, 16'h0055, 4'd4, 4'd4, 4'd0, 1, 0, 1));
    step(1, 1, 16'h4402, 16'd1, 16'd0, 0, 0, CK_ALL, 1, 0, 16'h0002, 4'd4, 4'd0, ve(0));
    step(1, 1, 16'h4402, 16'd1, 16'd0, 0, 0, CK_HB, 0, 0, 16'h0, 4'd0, 4'd0,
         fe(1, 4'h4, 16'd1, 16'd2, 16'd0, 4'd4, 4'd4, 4'd0, 0, 0, 1));
    step(1, 1, 16'h6403, 16'h1000, 16'h0055, 0, 0, CK_HB, 0, 0, 16'h0, 4'd0, 4'd0,
         fe(1, 4'h0, 16'h1000, 16'h0003, 16'h0055, 4'd4, 4'd4, 4'd0, 1, 0, 1));
    step(0, 1, 16'h0541, 16'd9, 16'd2, 0, 0, CK_HB, 1, 0, 16'h0, 4'd0, 4'd0, ze());
    step(1, 1, 16'h0541, 16'd9, 16'd2, 0, 0, CK_HB, 0, 0, 16'h0, 4'd0, 4'd0,
         fe(1, 4'h0, 16'd9, 16'd2, 16'd2, 4'd5, 4'd5, 4'd4, 0, 0, 1));

    // final report
    repeat (2) @(posedge clk);
    #3;
    check("queue_drained", EW'(exp_q.size()), EW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
